// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with a per-entry saturating-counter BHT; combinational IF lookup, EX-stage training.
// Optional BP_STATS_EN adds saturating branch / mispredict event counters.
module branch_predictor_btb #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 12,
    parameter int CNT_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TLO = 2 + IDX;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_ONE << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_ONE;

    logic [ENTRIES-1:0]                valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q,    tag_d;
    logic [ENTRIES-1:0][31:0]          target_q, target_d;
    logic [ENTRIES-1:0][CNT_BITS-1:0]  cnt_q,    cnt_d;

    logic [IDX-1:0]      if_idx, upd_idx;
    logic [TAG_BITS-1:0] if_tag, upd_tag;
    logic                if_hit, upd_hit;

    assign if_idx  = pc_if[TLO-1:2];
    assign if_tag  = pc_if[TLO+TAG_BITS-1:TLO];
    assign upd_idx = upd_pc[TLO-1:2];
    assign upd_tag = upd_pc[TLO+TAG_BITS-1:TLO];

    // Bits outside index/tag do not take part in lookup.
    logic unused_pc;
    assign unused_pc = ^{pc_if, upd_pc};

    // Lookup reads registered state only, so a same-cycle update is not visible.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && cnt_q[if_idx][CNT_BITS-1];
        pred_target = if_hit ? target_q[if_idx] : pc_if + 32'd4;
    end

    always_comb begin
        mispredict  = upd_en && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    if (cnt_q[upd_idx] != CNT_MAX)
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_ONE;
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_ONE;
                end
            end else if (upd_taken) begin
                // Not-taken misses never allocate, keeping the table for taken branches.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = CNT_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            cnt_q    <= {ENTRIES{CNT_WNT}};
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (upd_en && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (mispredict && (stat_mispred_q != 32'hFFFF_FFFF))
            stat_mispred_d = stat_mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (default parameters: 64 entries, 12-bit tag, 2-bit counters).
module tb_branch_predictor_btb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int total = 0;
    int bad   = 0;

    branch_predictor_btb dut (
        .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic idle;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        pc_if = 32'h100;
        idle();
        #3;
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First taken branch at 0x100 mispredicts and allocates; lookup same cycle sees old state
        upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        #1;
        chk("alloc_mispredict", {31'b0, mispredict}, 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h40);
        chk("same_cycle_old_taken", {31'b0, pred_taken}, 32'd0);
        chk("same_cycle_old_target", pred_target, 32'h104);
        tick();
        idle();
        #1;
        chk("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("alloc_pred_target", pred_target, 32'h40);

        // Counter 2 -> saturates at 3, then two not-taken steps to 1
        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
            #1;
            chk("train_correct_no_mp", {31'b0, mispredict}, 32'd0);
            tick();
        end
        upd(32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        #1;
        chk("nt_mispredict", {31'b0, mispredict}, 32'd1);
        chk("nt_redirect", redirect_pc, 32'h104);
        tick();
        idle();
        #1;
        chk("one_nt_still_taken", {31'b0, pred_taken}, 32'd1);
        upd(32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        tick();
        idle();
        #1;
        chk("two_nt_not_taken", {31'b0, pred_taken}, 32'd0);
        chk("two_nt_hit_target", pred_target, 32'h40);

        // 0x200 shares index 0 with a different tag and evicts 0x100
        upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        tick();
        idle();
        #1;
        chk("evicted_taken", {31'b0, pred_taken}, 32'd0);
        chk("evicted_target", pred_target, 32'h104);
        pc_if = 32'h200;
        #1;
        chk("new_hit_taken", {31'b0, pred_taken}, 32'd1);
        chk("new_hit_target", pred_target, 32'h300);

        // Not-taken miss leaves the table alone
        upd(32'h104, 1'b0, 32'h999, 1'b0, 32'h108);
        tick();
        idle();
        pc_if = 32'h104;
        #1;
        chk("no_alloc_taken", {31'b0, pred_taken}, 32'd0);
        chk("no_alloc_target", pred_target, 32'h108);

        // Right direction, wrong target
        pc_if = 32'h200;
        upd(32'h200, 1'b1, 32'h80, 1'b1, 32'h300);
        #1;
        chk("tgt_mispredict", {31'b0, mispredict}, 32'd1);
        chk("tgt_redirect", redirect_pc, 32'h80);
        tick();
        idle();
        #1;
        chk("tgt_updated", pred_target, 32'h80);
        upd(32'h200, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        chk("tgt_correct_no_mp", {31'b0, mispredict}, 32'd0);
        tick();

        // upd_en low: no mispredict and no state change
        upd(32'h200, 1'b0, 32'h0, 1'b1, 32'h80);
        upd_en = 1'b0;
        #1;
        chk("disabled_no_mp", {31'b0, mispredict}, 32'd0);
        tick();
        tick();
        chk("disabled_keeps_taken", {31'b0, pred_taken}, 32'd1);
        idle();

        // Address wrap at the top of the space
        pc_if = 32'hFFFF_FFFC;
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        #1;
        chk("wrap_pred_target", pred_target, 32'h0);
        chk("wrap_redirect", redirect_pc, 32'h0);
        tick();
        idle();

        // Mid-run reset clears the entry and discards an update in flight
        pc_if = 32'h200;
        rst_n = 1'b0;
        #1;
        chk("midrst_taken", {31'b0, pred_taken}, 32'd0);
        chk("midrst_target", pred_target, 32'h204);
        upd(32'h200, 1'b1, 32'h500, 1'b0, 32'h204);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("midrst_discard_taken", {31'b0, pred_taken}, 32'd0);
        chk("midrst_discard_target", pred_target, 32'h204);
        tick();

`ifdef BP_STATS_EN
        chk("stat_br_reset", stat_branches, 32'd0);
        chk("stat_mp_reset", stat_mispred, 32'd0);
        for (int i = 0; i < 10; i++) begin
            upd(32'h400 + 32'(i) * 32'd4, 1'b0, 32'h0, (i < 3), 32'h0);
            tick();
        end
        idle();
        #1;
        chk("stat_branches_10", stat_branches, 32'd10);
        chk("stat_mispred_3", stat_mispred, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
